// File: rtl/mult_pkg.sv
// Shared constants and helpers for the round-robin multiplier scheduler.
package mult_pkg;

   localparam int MULT_WIDTH = 16;
   localparam int MULT_LAT   = 2;
   localparam int MULT_MAXN  = 8;

   // Returns a MULT_MAXN-bit one-hot of idx; bits at or above n stay zero.
   function automatic logic [MULT_MAXN-1:0] onehot(input int idx, input int n);
      logic [MULT_MAXN-1:0] v;
      v = '0;
      for (int i = 0; i < MULT_MAXN; i++) begin
         v[i] = (i == idx) && (i < n);
      end
      return v;
   endfunction

endpackage

// File: rtl/mult_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search begins one past ptr and wraps.
module rr_arbiter
   import mult_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx,
   output logic          any
);

   logic          hit;
   logic [PW-1:0] sel;

   always_comb begin
      int idx;
      idx = 0;
      hit = 1'b0;
      sel = '0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!hit && req[idx]) begin
            hit = 1'b1;
            sel = PW'(idx);
         end
      end
   end

   always_comb begin
      any     = hit & en;
      gnt_idx = sel;
      gnt     = any ? N'(onehot(int'(sel), N)) : '0;
   end

endmodule

// File: rtl/mult_rr_sched.sv
// Shares one two-stage pipelined unsigned multiplier among NREQ requesters;
// results come back MULT_LAT cycles after the grant, tagged one-hot.
module mult_rr_sched
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int NREQ  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hold,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [2*WIDTH-1:0]    rsp_y,
   output logic                  busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IW-1:0]      ptr;
   logic [IW-1:0]      gnt_idx;
   logic               xfer;
   logic [WIDTH-1:0]   a_sel, b_sel;

   logic [WIDTH-1:0]   areg, breg;
   logic               v1, v2;
   logic [IW-1:0]      id1, id2;
   logic [2*WIDTH-1:0] yreg;

   // Reset also blocks grants so nothing is accepted into a pipeline being cleared.
   rr_arbiter #(.N(NREQ), .PW(IW)) u_arb (
      .req     (req_valid),
      .ptr     (ptr),
      .en      (!hold && !rst),
      .gnt     (req_ready),
      .gnt_idx (gnt_idx),
      .any     (xfer)
   );

   assign a_sel = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
   assign b_sel = req_b[int'(gnt_idx)*WIDTH +: WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr  <= IW'(NREQ-1);
         areg <= '0;
         breg <= '0;
         v1   <= 1'b0;
         id1  <= '0;
         yreg <= '0;
         v2   <= 1'b0;
         id2  <= '0;
      end else begin
         if (xfer) ptr <= gnt_idx;
         areg <= a_sel;
         breg <= b_sel;
         v1   <= xfer;
         id1  <= gnt_idx;
         yreg <= {{WIDTH{1'b0}}, areg} * {{WIDTH{1'b0}}, breg};
         v2   <= v1;
         id2  <= id1;
      end
   end

   assign rsp_y     = yreg;
   assign rsp_valid = v2 ? NREQ'(onehot(int'(id2), NREQ)) : '0;
   assign busy      = v1 | v2;

endmodule
